// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// default frame geometry used by both the start detector and the data-bit stage.
package uart_pkg;

  localparam int unsigned OSR_DEFAULT       = 16;
  localparam int unsigned DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Frame position counter must hold OSR*DATA_BITS-1 while spanning the data bits.
  function automatic int unsigned frame_cnt_width(input int unsigned osr,
                                                  input int unsigned bits);
    return $clog2(osr * bits + 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchroniser for the raw RX line; resets to the idle (high)
// level so a reset never looks like a start bit.
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) sync_q <= '1;
    else        sync_q <= {sync_q[STAGES-2:0], i_d};
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_start_detect.sv
// UART receive front end: synchronises RX, generates the oversample tick,
// validates the start bit at mid-bit and follows the frame to its stop bit.
module uart_rx_start_detect
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned OSR         = OSR_DEFAULT,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_rx,
  output logic o_tick,
  output logic o_rx_sync,
  output logic o_start,
  output logic o_busy,
  output logic o_frame_err
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = frame_cnt_width(OSR, DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] START_MID  = CNT_W'(OSR / 2 - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(OSR * DATA_BITS - 1);
  localparam logic [CNT_W-1:0] STOP_MID   = CNT_W'(OSR - 1);

  logic             rx_sync;
  logic             tick;
  logic [DIV_W-1:0] div_cnt_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_pulse;
  logic             frame_err_pulse;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt_q <= '0;
    end else if (i_en) begin
      div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign tick = i_en && (div_cnt_q == DIV_LAST);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    start_pulse     = 1'b0;
    frame_err_pulse = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_d = ST_START;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_START: begin
          // A high sample on any tick, including the mid-bit one, is a glitch.
          if (rx_sync) begin
            state_d = ST_IDLE;
          end else if (cnt_q == START_MID) begin
            start_pulse = 1'b1;
            state_d     = ST_DATA;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_d = ST_STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt_q == STOP_MID) begin
            cnt_d = '0;
            if (rx_sync) begin
              state_d = ST_IDLE;
            end else begin
              frame_err_pulse = 1'b1;
              state_d         = ST_BREAK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BREAK: begin
          // Wait for the line to go idle so a held-low line cannot retrigger.
          if (rx_sync) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_tick      = tick;
  assign o_rx_sync   = rx_sync;
  assign o_start     = start_pulse;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_frame_err = frame_err_pulse;

endmodule

// File: tb/tb_uart_rx_start_detect.sv
// Bench for uart_rx_start_detect: a frame-position model checked every cycle,
// plus directed scenarios with hand-computed pulse counts and latencies.
module tb_uart_rx_start_detect;

  localparam int CLK_DIV   = 4;
  localparam int OSR       = 16;
  localparam int DATA_BITS = 8;
  localparam int SYNC      = 2;
  localparam int LOG       = 8192;
  localparam int BIT_CLKS  = OSR * CLK_DIV;
  // Tick offsets counted from the first low sample of a frame.
  localparam int START_POS = OSR / 2 - 1;
  localparam int STOP_POS  = START_POS + OSR * DATA_BITS + OSR;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic rx    = 1'b1;
  logic o_tick, o_rx_sync, o_start, o_busy, o_frame_err;

  always #5 clk = ~clk;

  uart_rx_start_detect #(
    .CLK_DIV(CLK_DIV), .OSR(OSR), .DATA_BITS(DATA_BITS), .SYNC_STAGES(SYNC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_en        (en),
    .i_rx        (rx),
    .o_tick      (o_tick),
    .o_rx_sync   (o_rx_sync),
    .o_start     (o_start),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  // rx_log remembers the line per clock; the synchronised line is simply the
  // value SYNC clocks ago. mode: 0 idle, 1 inside a frame, 2 line broken low.
  bit rx_log [0:LOG-1];
  int m_cyc;
  int en_clocks;
  int mode;
  int pos;

  function automatic bit m_sync();
    return (m_cyc >= SYNC) ? rx_log[(m_cyc - SYNC) % LOG] : 1'b1;
  endfunction

  function automatic bit m_tick();
    return en && ((en_clocks % CLK_DIV) == CLK_DIV - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc     <= 0;
      en_clocks <= 0;
      mode      <= 0;
      pos       <= 0;
    end else begin
      rx_log[m_cyc % LOG] <= rx;
      m_cyc <= m_cyc + 1;
      if (en) en_clocks <= en_clocks + 1;
      if (m_tick()) begin
        case (mode)
          0: if (!m_sync()) begin mode <= 1; pos <= 1; end
          1: begin
            if (pos <= START_POS && m_sync()) mode <= 0;
            else if (pos == STOP_POS)         mode <= m_sync() ? 0 : 2;
            else                              pos  <= pos + 1;
          end
          default: if (m_sync()) mode <= 0;
        endcase
      end
    end
  end

  // ---------------- compare process and statistics ----------------
  int cyc = 0;
  int n_start, n_ferr, busy_ticks, start_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit t, s;
    t = m_tick();
    s = m_sync();
    check("tick",      o_tick,      t);
    check("rx_sync",   o_rx_sync,   s);
    check("busy",      o_busy,      mode != 0);
    check("start",     o_start,     t && mode == 1 && pos == START_POS && !s);
    check("frame_err", o_frame_err, t && mode == 1 && pos == STOP_POS && !s);
    if (o_start) begin n_start++; start_cyc = cyc; end
    if (o_frame_err) n_ferr++;
    if (o_tick && o_busy) busy_ticks++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_start = 0; n_ferr = 0; busy_ticks = 0; start_cyc = -1;
  endtask

  // Puts the next input change right after a tick edge, so every frame starts
  // at the same divider phase.
  task automatic align();
    bit found = 1'b0;
    for (int k = 0; k < 4 * CLK_DIV && !found; k++) begin
      @(negedge clk);
      if (o_tick) found = 1'b1;
    end
    if (!found) check("align_tick_seen", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Drives start bit, LSB-first data, stop bit and extra_low ticks of low line.
  // en is dropped for en_off_len clocks at clock en_off_at; rst_at >= 0 asserts
  // reset at that clock and returns with reset held.
  task automatic send_frame(input logic [7:0] data, input bit stop, input int extra_low,
                            input int en_off_at, input int en_off_len, input int rst_at,
                            output int t0);
    int total;
    int idx;
    align();
    t0    = cyc;
    total = (DATA_BITS + 2) * BIT_CLKS + extra_low * CLK_DIV;
    for (int k = 0; k < total; k++) begin
      idx = k / BIT_CLKS;
      if (idx == 0)                   rx = 1'b0;
      else if (idx <= DATA_BITS)      rx = data[idx-1];
      else if (idx == DATA_BITS + 1)  rx = stop;
      else                            rx = 1'b0;
      en = !(en_off_at >= 0 && k >= en_off_at && k < en_off_at + en_off_len);
      if (k == rst_at) begin
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("busy_drops_in_reset_cycle", o_busy, 0);
        check("no_start_in_reset",         o_start, 0);
        check("no_ferr_in_reset",          o_frame_err, 0);
        return;
      end
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, gap, d2, d6;
    clear_stats();
    en = 1'b1;
    rx = 1'b1;

    // 1. Reset asserted mid-way through a tick period
    clocks(3);
    rst_n = 1'b1;
    clocks(6);
    rst_n = 1'b0;
    #1;
    check("reset_rx_sync", o_rx_sync, 1);
    check("reset_busy",    o_busy,    0);
    check("reset_tick",    o_tick,    0);
    clocks(3);
    rst_n = 1'b1;
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_tick) break;
      gap++;
    end
    check("tick_gap_after_release", gap, 3);

    // 2. Frame 0x55 with a good stop bit
    clear_stats();
    send_frame(8'h55, 1'b1, 0, -1, 0, -1, t0);
    clocks(100);
    d2 = start_cyc - t0;
    check("s2_start_count", n_start, 1);
    check("s2_ferr_count",  n_ferr,  0);
    // Detecting tick plus 151 busy ticks spans 8+128+16 ticks.
    check("s2_busy_ticks",  busy_ticks, 151);
    // 2 clocks sync, detect on the tick after, then 7 more ticks to mid-bit.
    check("s2_start_latency_clocks", d2, 31);
    check("s2_idle_after", o_busy, 0);

    // 3. Three low ticks then high: glitch
    clear_stats();
    align();
    rx = 1'b0;
    clocks(12);
    rx = 1'b1;
    clocks(3);
    check("s3_busy_before_4th_tick", o_busy, 1);
    clocks(1);
    check("s3_idle_after_4th_tick",  o_busy, 0);
    clocks(20);
    check("s3_start_count", n_start, 0);

    // 4. Frame 0x00 with a low stop bit, line held low 40 more ticks
    clear_stats();
    send_frame(8'h00, 1'b0, 40, -1, 0, -1, t0);
    check("s4_break_holds_busy", o_busy, 1);
    clocks(20);
    check("s4_ferr_count",  n_ferr,  1);
    check("s4_start_count", n_start, 1);
    check("s4_idle_after",  o_busy,  0);

    // 5. Reset at tick 50 of a frame
    clear_stats();
    send_frame(8'h55, 1'b1, 0, -1, 0, 4 + 50 * CLK_DIV, t0);
    check("s5_start_before_reset", n_start, 1);
    clear_stats();
    clocks(3);
    rst_n = 1'b1;
    clocks(700);
    check("s5_start_after_reset", n_start, 0);
    check("s5_ferr_after_reset",  n_ferr,  0);
    check("s5_idle",              o_busy,  0);

    // 6. Enable low for 20 clocks during START
    clear_stats();
    send_frame(8'h55, 1'b1, 0, 12, 20, -1, t0);
    clocks(100);
    d6 = start_cyc - t0;
    check("s6_start_count", n_start, 1);
    check("s6_ferr_count",  n_ferr,  0);
    check("s6_busy_ticks",  busy_ticks, 151);
    check("s6_start_delay_vs_s2", d6 - d2, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
